mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
- Multi-cycle control FSM for the MIPS CPU core.
- Owns the PC, instruction register (IR), ALU-output register and memory-data register (MDR).
- Sequences fetch, execute, memory and writeback over the shared ALU, register file and single-port memory bus.
- Decodes ADDU/ADDIU/LW/JR into the ALU's 7-bit internal opcode; asserts halt when the program jumps to address 0.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
WORD_BYTES, 4, PC increment per instruction

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
mem_address  output  32  bus byte address
mem_read  output  1  read strobe
mem_waitrequest  input  1  bus stall; current access held while 1
mem_readdata  input  32  read data, valid when mem_read=1 and mem_waitrequest=0
rf_addr_a  output  5  register-file read port A (rs)
rf_addr_b  output  5  register-file read port B (rt)
rf_data_a  input  32  combinational read data A
rf_data_b  input  32  combinational read data B
rf_write_en  output  1  register-file write strobe
rf_write_addr  output  5  write register index
rf_write_data  output  32  write data
alu_a  output  32  ALU operand a
alu_b  output  32  ALU operand b
alu_op  output  7  ALU internal opcode
alu_r  input  32  ALU result (combinational)
active  output  1  1 while executing, 0 once halted

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low. It is sampled only on the rising edge of `clk` and overrides all other activity, including mid-access.
- Reset values: state=FETCH, pc=RESET_VECTOR, ir/alu_out/mdr=0, jump_pending=0, active=1.
- State-decoded outputs default to 0 / ALU_NONE outside their states.
- Internal opcodes: ALU_NONE=0, ADDIU=3, ADDU=4, JR=25, LW=47. Any other instruction decodes to ALU_NONE and executes as a NOP.
- FETCH:
  - mem_read=1, mem_address=pc.
  - Hold while mem_waitrequest=1.
  - Otherwise ir<=mem_readdata and go to EXEC.
- EXEC:
  - rf_addr_a=ir[25:21], rf_addr_b=ir[20:16].
  - alu_a=rf_data_a.
  - alu_b=rf_data_b for ADDU; sign-extended ir[15:0] for ADDIU/LW.
  - alu_op=decoded opcode; alu_out<=alu_r.
  - ADDU/ADDIU go to WB. LW goes to MEM.
  - JR: target<=rf_data_a, jump_pending<=1, pc<=pc+4, go to FETCH. The following instruction is the delay slot.
  - NOP: pc update as in WB, then FETCH.
- MEM:
  - mem_read=1, mem_address=alu_out.
  - Hold on waitrequest; otherwise mdr<=mem_readdata and go to WB.
  - If alu_out[1:0]!=0, no bus access: go straight to HALTED, active<=0.
- WB (exactly one cycle):
  - rf_write_en=1.
  - rf_write_addr=ir[15:11] for ADDU, ir[20:16] for ADDIU/LW.
  - rf_write_data=alu_out, or mdr for LW.
  - rf_write_en is forced 0 when rf_write_addr==0.
  - pc update, then FETCH.
- pc update, applied at end of WB or NOP:
  - If jump_pending, pc<=target and jump_pending<=0; if target==0, go to HALTED instead of FETCH.
  - Otherwise pc<=pc+4 (32-bit wrap, no trap).
- JR in a delay slot (jump_pending already 1) executes as NOP; the pending target wins.
- HALTED: active=0, mem_read=0, rf_write_en=0. Remain until reset.
- Latency without wait states:
  - ADDU/ADDIU: 3 cycles.
  - LW: 4 cycles.
  - JR/NOP: 2 cycles.
  - Each waitrequest cycle adds 1.

Decomposition:
- Package mips_pkg:
  - opcode_internal enum (shared with ALU).
  - state_t enum {FETCH, EXEC, MEM, WB, HALTED}.
  - MIPS primary/funct field constants.
  - RESET_VECTOR default.
- Sub-module mips_instr_decode (combinational): ir maps to alu_op, use_imm, is_load, is_jr, and dest register select.

Test Plan:
- Release reset with mem_waitrequest=1 for 3 cycles: mem_address=BFC00000 and mem_read held for 4 cycles, then EXEC.
- ADDIU $2,$0,5 with rf_data_a=0: alu_b=5, alu_op=3, WB writes reg 2 = 5, next fetch at BFC00004.
- ADDU $0,$1,$1: rf_write_en stays 0 in WB; pc advances by 4.
- LW $3,-4($4) with rf_data_a=0x1008 and 2 wait states: MEM address=0x1004, reg 3 = mem_readdata; 6 cycles total.
- JR $5 with rf_data_a=0, then ADDIU in delay slot: slot writes its result, then HALTED with active=0 and no further mem_read.
- rst_n=0 for one edge during MEM wait: next cycle FETCH at BFC00000 with active=1; no rf write occurs.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller:
// the ALU internal opcode set, FSM states and instruction field encodings.
package mips_pkg;

   typedef enum logic [6:0] {
      ALU_NONE  = 7'd0,
      ALU_ADDIU = 7'd3,
      ALU_ADDU  = 7'd4,
      ALU_JR    = 7'd25,
      ALU_LW    = 7'd47
   } opcode_internal_t;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      EXEC   = 3'd1,
      MEM    = 3'd2,
      WB     = 3'd3,
      HALTED = 3'd4
   } state_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_ADDU    = 6'h21;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational instruction decoder: maps an instruction word to the ALU
// internal opcode plus operand, load, jump and destination-select flags.
module mips_instr_decode
   import mips_pkg::*;
(
   input  logic [31:0]      i_ir,
   output opcode_internal_t o_alu_op,
   output logic             o_use_imm,
   output logic             o_is_load,
   output logic             o_is_jr,
   output logic             o_dest_rt
);

   logic [5:0] w_opcode;
   logic [5:0] w_funct;

   assign w_opcode = i_ir[31:26];
   assign w_funct  = i_ir[5:0];

   // Unrecognised encodings fall through to ALU_NONE and execute as NOPs.
   always_comb begin
      o_alu_op  = ALU_NONE;
      o_use_imm = 1'b0;
      o_is_load = 1'b0;
      o_is_jr   = 1'b0;
      o_dest_rt = 1'b0;
      case (w_opcode)
         OP_SPECIAL: begin
            case (w_funct)
               FN_ADDU: o_alu_op = ALU_ADDU;
               FN_JR: begin
                  o_alu_op = ALU_JR;
                  o_is_jr  = 1'b1;
               end
               default: o_alu_op = ALU_NONE;
            endcase
         end
         OP_ADDIU: begin
            o_alu_op  = ALU_ADDIU;
            o_use_imm = 1'b1;
            o_dest_rt = 1'b1;
         end
         OP_LW: begin
            o_alu_op  = ALU_LW;
            o_use_imm = 1'b1;
            o_is_load = 1'b1;
            o_dest_rt = 1'b1;
         end
         default: o_alu_op = ALU_NONE;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: owns PC/IR/ALU-out/MDR and sequences
// fetch, execute, memory and writeback over shared ALU, regfile and bus.
module mips_multicycle_controller
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [31:0] WORD_BYTES   = 32'd4
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] mem_address,
   output logic        mem_read,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   output logic [4:0]  rf_addr_a,
   output logic [4:0]  rf_addr_b,
   input  logic [31:0] rf_data_a,
   input  logic [31:0] rf_data_b,
   output logic        rf_write_en,
   output logic [4:0]  rf_write_addr,
   output logic [31:0] rf_write_data,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [6:0]  alu_op,
   input  logic [31:0] alu_r,
   output logic        active
);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_alu_out;
   logic [31:0] r_mdr;
   logic [31:0] r_target;
   logic        r_jump_pending;
   logic        r_active;

   opcode_internal_t w_alu_op;
   logic             w_use_imm;
   logic             w_is_load;
   logic             w_is_jr;
   logic             w_dest_rt;
   logic [31:0]      w_upd_pc;
   logic             w_upd_halt;
   logic             w_misaligned;
   logic [4:0]       w_wr_addr;

   mips_instr_decode u_decode (
      .i_ir      (r_ir),
      .o_alu_op  (w_alu_op),
      .o_use_imm (w_use_imm),
      .o_is_load (w_is_load),
      .o_is_jr   (w_is_jr),
      .o_dest_rt (w_dest_rt)
   );

   // Commit-time PC: a pending delay-slot jump wins; a jump to 0 halts.
   assign w_upd_pc     = r_jump_pending ? r_target : (r_pc + WORD_BYTES);
   assign w_upd_halt   = r_jump_pending && (r_target == 32'd0);
   assign w_misaligned = (r_alu_out[1:0] != 2'b00);
   assign w_wr_addr    = w_dest_rt ? r_ir[20:16] : r_ir[15:11];
   assign active       = r_active;

   // Control FSM and architectural state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= FETCH;
         r_pc           <= RESET_VECTOR;
         r_ir           <= 32'd0;
         r_alu_out      <= 32'd0;
         r_mdr          <= 32'd0;
         r_target       <= 32'd0;
         r_jump_pending <= 1'b0;
         r_active       <= 1'b1;
      end else begin
         case (r_state)
            FETCH: begin
               if (!mem_waitrequest) begin
                  r_ir    <= mem_readdata;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_alu_out <= alu_r;
               if (w_is_jr && !r_jump_pending) begin
                  r_target       <= rf_data_a;
                  r_jump_pending <= 1'b1;
                  r_pc           <= r_pc + WORD_BYTES;
                  r_state        <= FETCH;
               end else if (w_is_load) begin
                  r_state <= MEM;
               end else if ((w_alu_op == ALU_ADDU) || (w_alu_op == ALU_ADDIU)) begin
                  r_state <= WB;
               end else begin
                  r_pc           <= w_upd_pc;
                  r_jump_pending <= 1'b0;
                  r_state        <= w_upd_halt ? HALTED : FETCH;
                  r_active       <= !w_upd_halt;
               end
            end
            MEM: begin
               if (w_misaligned) begin
                  r_state  <= HALTED;
                  r_active <= 1'b0;
               end else if (!mem_waitrequest) begin
                  r_mdr   <= mem_readdata;
                  r_state <= WB;
               end
            end
            WB: begin
               r_pc           <= w_upd_pc;
               r_jump_pending <= 1'b0;
               r_state        <= w_upd_halt ? HALTED : FETCH;
               r_active       <= !w_upd_halt;
            end
            HALTED: begin
               r_active <= 1'b0;
            end
            default: begin
               r_state  <= HALTED;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   // State-decoded bus, regfile and ALU controls; idle values elsewhere.
   always_comb begin
      mem_address   = 32'd0;
      mem_read      = 1'b0;
      rf_addr_a     = 5'd0;
      rf_addr_b     = 5'd0;
      rf_write_en   = 1'b0;
      rf_write_addr = 5'd0;
      rf_write_data = 32'd0;
      alu_a         = 32'd0;
      alu_b         = 32'd0;
      alu_op        = ALU_NONE;
      case (r_state)
         FETCH: begin
            mem_read    = 1'b1;
            mem_address = r_pc;
         end
         EXEC: begin
            rf_addr_a = r_ir[25:21];
            rf_addr_b = r_ir[20:16];
            alu_a     = rf_data_a;
            alu_op    = w_alu_op;
            if (w_use_imm) begin
               alu_b = sign_ext16(r_ir[15:0]);
            end else if (w_alu_op == ALU_ADDU) begin
               alu_b = rf_data_b;
            end else begin
               alu_b = 32'd0;
            end
         end
         MEM: begin
            mem_read    = !w_misaligned;
            mem_address = w_misaligned ? 32'd0 : r_alu_out;
         end
         WB: begin
            rf_write_addr = w_wr_addr;
            rf_write_en   = (w_wr_addr != 5'd0);
            rf_write_data = w_is_load ? r_mdr : r_alu_out;
         end
         default: begin
            mem_read = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed self-checking bench for the multi-cycle MIPS controller, with a
// small register-file array and an adder standing in for the ALU.
module tb_mips_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic [4:0]  rf_addr_a;
   logic [4:0]  rf_addr_b;
   logic [31:0] rf_data_a;
   logic [31:0] rf_data_b;
   logic        rf_write_en;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [6:0]  alu_op;
   logic [31:0] alu_r;
   logic        active;

   logic [31:0] regs [32];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rf_data_a = regs[rf_addr_a];
   assign rf_data_b = regs[rf_addr_b];
   assign alu_r     = alu_a + alu_b;

   mips_multicycle_controller dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_waitrequest (mem_waitrequest),
      .mem_readdata    (mem_readdata),
      .rf_addr_a       (rf_addr_a),
      .rf_addr_b       (rf_addr_b),
      .rf_data_a       (rf_data_a),
      .rf_data_b       (rf_data_b),
      .rf_write_en     (rf_write_en),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_op          (alu_op),
      .alu_r           (alu_r),
      .active          (active)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are then driven 2 time units after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] instr);
      mem_waitrequest = 1'b0;
      mem_readdata    = instr;
      #1;
      check_value("fetch_addr", mem_address, exp_pc);
      check_value("fetch_read", {31'd0, mem_read}, 32'd1);
      step();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      mem_waitrequest = 1'b1;
      mem_readdata    = 32'd0;
      rst_n           = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      #1;
      check_value("rst_active", {31'd0, active}, 32'd1);
      check_value("rst_addr", mem_address, 32'hBFC0_0000);
      check_value("rst_wen", {31'd0, rf_write_en}, 32'd0);

      // Reset released with three wait-state cycles on the first fetch.
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_value("wait_addr", mem_address, 32'hBFC0_0000);
         check_value("wait_read", {31'd0, mem_read}, 32'd1);
         step();
      end

      // ADDIU $2,$0,5
      fetch(32'hBFC0_0000, 32'h2402_0005);
      #1;
      check_value("addiu_op", {25'd0, alu_op}, 32'd3);
      check_value("addiu_b", alu_b, 32'd5);
      check_value("addiu_exec_read", {31'd0, mem_read}, 32'd0);
      step();
      #1;
      check_value("addiu_wen", {31'd0, rf_write_en}, 32'd1);
      check_value("addiu_waddr", {27'd0, rf_write_addr}, 32'd2);
      check_value("addiu_wdata", rf_write_data, 32'd5);
      step();

      // ADDU $0,$1,$1 : write to $0 suppressed
      regs[1] = 32'd7;
      fetch(32'hBFC0_0004, 32'h0021_0021);
      #1;
      check_value("addu_op", {25'd0, alu_op}, 32'd4);
      check_value("addu_b", alu_b, 32'd7);
      step();
      #1;
      check_value("addu_wen", {31'd0, rf_write_en}, 32'd0);
      step();

      // LW $3,-4($4) with two wait states in MEM
      regs[4] = 32'h0000_1008;
      fetch(32'hBFC0_0008, 32'h8C83_FFFC);
      #1;
      check_value("lw_op", {25'd0, alu_op}, 32'd47);
      check_value("lw_b", alu_b, 32'hFFFF_FFFC);
      step();
      mem_waitrequest = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_value("lw_mem_addr", mem_address, 32'h0000_1004);
         check_value("lw_mem_read", {31'd0, mem_read}, 32'd1);
         step();
      end
      mem_waitrequest = 1'b0;
      mem_readdata    = 32'hDEAD_BEEF;
      #1;
      check_value("lw_mem_addr", mem_address, 32'h0000_1004);
      step();
      #1;
      check_value("lw_wen", {31'd0, rf_write_en}, 32'd1);
      check_value("lw_waddr", {27'd0, rf_write_addr}, 32'd3);
      check_value("lw_wdata", rf_write_data, 32'hDEAD_BEEF);
      step();

      // NOP (word 0) takes two cycles
      fetch(32'hBFC0_000C, 32'h0000_0000);
      #1;
      check_value("nop_op", {25'd0, alu_op}, 32'd0);
      step();

      // JR $5 (=0) then ADDIU $6,$0,9 in the delay slot, then halt
      fetch(32'hBFC0_0010, 32'h00A0_0008);
      #1;
      check_value("jr_op", {25'd0, alu_op}, 32'd25);
      step();
      fetch(32'hBFC0_0014, 32'h2406_0009);
      step();
      #1;
      check_value("slot_wen", {31'd0, rf_write_en}, 32'd1);
      check_value("slot_waddr", {27'd0, rf_write_addr}, 32'd6);
      check_value("slot_wdata", rf_write_data, 32'd9);
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         check_value("halt_active", {31'd0, active}, 32'd0);
         check_value("halt_read", {31'd0, mem_read}, 32'd0);
         step();
      end

      // Reset asserted for one edge while a load waits in MEM
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      fetch(32'hBFC0_0000, 32'h8C83_FFFC);
      step();
      mem_waitrequest = 1'b1;
      #1;
      check_value("mrst_mem_addr", mem_address, 32'h0000_1004);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      check_value("mrst_addr", mem_address, 32'hBFC0_0000);
      check_value("mrst_active", {31'd0, active}, 32'd1);
      check_value("mrst_read", {31'd0, mem_read}, 32'd1);
      check_value("mrst_wen", {31'd0, rf_write_en}, 32'd0);
      step();
      #1;
      check_value("mrst_wen2", {31'd0, rf_write_en}, 32'd0);

      // Misaligned load address halts without a bus access
      regs[4] = 32'h0000_1009;
      fetch(32'hBFC0_0000, 32'h8C83_FFFC);
      step();
      #1;
      check_value("mis_read", {31'd0, mem_read}, 32'd0);
      step();
      #1;
      check_value("mis_active", {31'd0, active}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
